// File: rtl/core_acc_pkg.sv
// Shared types and default sizing for the partial-sum accumulator.
// The tile sequencer and its lane adders both import this package.
package core_acc_pkg;

  localparam int COL_DEF      = 8;
  localparam int PSUM_BW_DEF  = 16;
  localparam int FINAL_BW_DEF = 24;
  localparam int LEN_KIJ_DEF  = 9;
  localparam int LEN_ONIJ_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter width for an index that ranges over 0..n-1.
  // The result is never zero, so a single-entry range still gets a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_sat_lane.sv
// One accumulator lane. It sign-extends a partial sum, then either overwrites
// the stored value (first kernel position) or adds to it with a signed saturating clamp.
module acc_sat_lane
  import core_acc_pkg::*;
#(
  parameter int PSUM_BW  = PSUM_BW_DEF,
  parameter int FINAL_BW = FINAL_BW_DEF
) (
  input  logic                first,
  input  logic [PSUM_BW-1:0]  psum,
  input  logic [FINAL_BW-1:0] acc_in,
  output logic [FINAL_BW-1:0] acc_out,
  output logic                sat
);

  logic signed [PSUM_BW-1:0] psum_s;
  logic        [FINAL_BW-1:0] ext;
  logic        [FINAL_BW:0]   sum;

  assign psum_s = psum;
  assign ext    = FINAL_BW'(psum_s);

  // The sum is one bit wider than the lane. It has overflowed when its top two bits disagree.
  assign sum = {ext[FINAL_BW-1], ext} + {acc_in[FINAL_BW-1], acc_in};

  always_comb begin
    acc_out = sum[FINAL_BW-1:0];
    sat     = 1'b0;
    if (first) begin
      acc_out = ext;
    end else if (sum[FINAL_BW] != sum[FINAL_BW-1]) begin
      sat     = 1'b1;
      acc_out = sum[FINAL_BW] ? {1'b1, {(FINAL_BW-1){1'b0}}}
                              : {1'b0, {(FINAL_BW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/core_acc_seq.sv
// Tile accumulator. It sums LEN_KIJ passes of LEN_ONIJ partial-sum beats into a
// register buffer, then drains one beat per output pixel with optional ReLU.
module core_acc_seq
  import core_acc_pkg::*;
#(
  parameter int COL      = COL_DEF,
  parameter int PSUM_BW  = PSUM_BW_DEF,
  parameter int FINAL_BW = FINAL_BW_DEF,
  parameter int LEN_KIJ  = LEN_KIJ_DEF,
  parameter int LEN_ONIJ = LEN_ONIJ_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [COL*PSUM_BW-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COL*FINAL_BW-1:0] out_data,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag
);

  localparam int KW = cnt_w(LEN_KIJ);
  localparam int OW = cnt_w(LEN_ONIJ);

  state_e state_q, state_d;
  logic [KW-1:0] kij_q, kij_d;
  logic [OW-1:0] onij_q, onij_d;
  logic [OW-1:0] drain_q, drain_d;
  logic          relu_q, relu_d;
  logic          sat_q, sat_d;

  logic [LEN_ONIJ-1:0][COL-1:0][FINAL_BW-1:0] buf_q, buf_d;

  logic [COL-1:0][FINAL_BW-1:0] lane_sum;
  logic [COL-1:0]               lane_sat;
  logic                         first_pass;
  logic                         xfer;
  logic                         onij_last, kij_last, drain_last;
  logic [FINAL_BW-1:0]          drain_lane;

  assign first_pass = (kij_q == '0);
  assign onij_last  = (onij_q  == OW'(LEN_ONIJ-1));
  assign kij_last   = (kij_q   == KW'(LEN_KIJ-1));
  assign drain_last = (drain_q == OW'(LEN_ONIJ-1));

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sat_flag  = sat_q;
  assign xfer      = in_valid & in_ready;

  for (genvar c = 0; c < COL; c++) begin : g_lane
    acc_sat_lane #(
      .PSUM_BW (PSUM_BW),
      .FINAL_BW(FINAL_BW)
    ) u_lane (
      .first  (first_pass),
      .psum   (in_data[c*PSUM_BW +: PSUM_BW]),
      .acc_in (buf_q[onij_q][c]),
      .acc_out(lane_sum[c]),
      .sat    (lane_sat[c])
    );
  end

  always_comb begin
    state_d = state_q;
    kij_d   = kij_q;
    onij_d  = onij_q;
    drain_d = drain_q;
    relu_d  = relu_q;
    sat_d   = sat_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          kij_d   = '0;
          onij_d  = '0;
          drain_d = '0;
          sat_d   = 1'b0;
          relu_d  = relu_en;
        end
      end
      ACCUM: begin
        if (xfer) begin
          buf_d[onij_q] = lane_sum;
          // The lane reports no saturation on the first pass, so this only fires for real sums.
          if (|lane_sat) sat_d = 1'b1;
          if (onij_last) begin
            onij_d = '0;
            if (kij_last) begin
              kij_d   = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              kij_d = kij_q + KW'(1);
            end
          end else begin
            onij_d = onij_q + OW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (drain_last) begin
            drain_d = '0;
            state_d = DONE;
          end else begin
            drain_d = drain_q + OW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The buffer does not change during DRAIN, so out_data stays put while the consumer stalls.
  always_comb begin
    out_data   = '0;
    drain_lane = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COL; c++) begin
        drain_lane = buf_q[drain_q][c];
        if (!(relu_q && drain_lane[FINAL_BW-1]))
          out_data[c*FINAL_BW +: FINAL_BW] = drain_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      kij_q   <= '0;
      onij_q  <= '0;
      drain_q <= '0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kij_q   <= kij_d;
      onij_q  <= onij_d;
      drain_q <= drain_d;
      relu_q  <= relu_d;
      sat_q   <= sat_d;
    end
  end

  // The first pass overwrites every buffer entry before it is read, so the buffer has no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: doc/core_acc_seq.md
CORE_ACC_SEQ -- requirements
Module: core_acc_seq

Interface
REQ-001 SHALL have parameter COL, default 8, number of output-channel lanes.
REQ-002 SHALL have parameter PSUM_BW, default 16, signed width of each incoming partial-sum lane.
REQ-003 SHALL have parameter FINAL_BW, default 24, signed width of each accumulated lane (FINAL_BW >= PSUM_BW).
REQ-004 SHALL have parameter LEN_KIJ, default 9, number of kernel positions accumulated per output pixel.
REQ-005 SHALL have parameter LEN_ONIJ, default 16, number of output pixels per tile.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-008 SHALL have port start, input, 1, one-cycle request to begin a tile.
REQ-009 SHALL have port relu_en, input, 1, ReLU mode, sampled when start is accepted.
REQ-010 SHALL have port in_valid, input, 1, partial-sum beat valid.
REQ-011 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-012 SHALL have port in_data, input, COL*PSUM_BW, partial-sum lanes; lane c at [c*PSUM_BW +: PSUM_BW].
REQ-013 SHALL have port out_valid, output, 1, final output beat valid.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts output beat.
REQ-015 SHALL have port out_data, output, COL*FINAL_BW, final lanes; lane c at [c*FINAL_BW +: FINAL_BW].
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at tile completion.
REQ-018 SHALL have port sat_flag, output, 1, sticky: some lane saturated during the current tile.

Function
REQ-019 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-020 SHALL, in IDLE with start=1: go to ACCUM, clear kij/onij counters and sat_flag, latch relu_en; start in any other state is ignored.
REQ-021 SHALL drive in_ready=1 only in ACCUM; a beat transfers on in_valid & in_ready at the clock edge.
REQ-022 SHALL store transferred beats into an internal LEN_ONIJ x COL x FINAL_BW register buffer at entry onij; onij increments per beat, wraps at LEN_ONIJ-1 to 0 and increments kij.
REQ-023 SHALL, when kij==0, write the sign-extended in_data lane (overwrite, no read of old contents).
REQ-024 SHALL, when kij>0, write the saturating signed sum of entry and sign-extended lane, clamped to [-2^(FINAL_BW-1), 2^(FINAL_BW-1)-1]; any clamp sets sat_flag.
REQ-025 SHALL, after the beat with kij==LEN_KIJ-1 and onij==LEN_ONIJ-1, enter DRAIN on the next cycle with drain index 0.
REQ-026 SHALL, in DRAIN, assert out_valid and present entry[drain index] on out_data, each lane replaced by 0 if latched relu_en=1 and the lane is negative.
REQ-027 SHALL hold out_data stable while out_valid=1 and out_ready=0; on out_valid & out_ready the drain index increments.
REQ-028 SHALL, after the handshake on drain index LEN_ONIJ-1, enter DONE; DONE asserts done for exactly one cycle and returns to IDLE.
REQ-029 SHALL drive out_data=0 whenever out_valid=0.
REQ-030 SHALL retain sat_flag from tile completion until the next accepted start or reset.

Reset
REQ-031 SHALL, on reset=0 at a clock edge, in any state including mid-tile, enter IDLE with in_ready=0, out_valid=0, out_data=0, busy=0, done=0, sat_flag=0, counters zero.
REQ-032 SHALL NOT require buffer contents to be reset; REQ-023 guarantees overwrite before use.

Structure
REQ-033 SHALL place the state enum and default parameter constants in shared package core_acc_pkg.
REQ-034 SHALL instantiate one sub-module acc_sat_lane per lane (sign-extend, saturating add, overflow flag), generated COL times.

Verification
REQ-035 SHALL cover: defaults, every lane=1 for all 144 beats, relu_en=0 -> 16 output beats, each lane=9, sat_flag=0, one done pulse.
REQ-036 SHALL cover: lane0=-5 for all beats, relu_en=1 -> lane0 outputs 0; relu_en=0 -> lane0 outputs -45.
REQ-037 SHALL cover: PSUM_BW=16, FINAL_BW=17, lane=32767 every beat -> outputs 65535 (clamped), sat_flag=1 after done.
REQ-038 SHALL cover: random in_valid gaps and out_ready low 3 cycles on beat 5 -> out_data held, no lost or duplicated beats, order onij 0..15.
REQ-039 SHALL cover: reset=0 mid-ACCUM (kij=4) then new tile -> outputs reflect only the new tile, no stale accumulation.
REQ-040 SHALL cover: start pulsed during ACCUM and DRAIN -> ignored, no extra tile, busy stays 1 until DONE.
